// File: rtl/alu_mul_sequencer_if.sv
// Bundle of the request, result and shared-ALU signals between the EX stage,
// the integer ALU and the shift-and-add multiply sequencer.
interface alu_mul_sequencer_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
);

  logic                     start;
  logic                     flush;
  logic [DATA_WIDTH-1:0]    op_a;
  logic [DATA_WIDTH-1:0]    op_b;
  logic                     busy;
  logic                     done;
  logic [DATA_WIDTH-1:0]    result;
  logic                     alu_req;
  logic                     alu_gnt;
  logic [DATA_WIDTH-1:0]    alu_src_a;
  logic [DATA_WIDTH-1:0]    alu_src_b;
  logic [OPCODE_LENGTH-1:0] alu_op;
  logic [DATA_WIDTH-1:0]    alu_result;

  // The pipeline/ALU side that issues multiplies and answers ALU requests.
  modport master (
    output start, flush, op_a, op_b, alu_gnt, alu_result,
    input  busy, done, result, alu_req, alu_src_a, alu_src_b, alu_op
  );

  // The multiply sequencer itself.
  modport slave (
    input  start, flush, op_a, op_b, alu_gnt, alu_result,
    output busy, done, result, alu_req, alu_src_a, alu_src_b, alu_op
  );

endinterface

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiplier producing the low DATA_WIDTH bits of A*B.
// All additions are borrowed from the shared integer ALU (ADD opcode), so the
// block itself contains only shifters, muxes and state.
module alu_mul_sequencer #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input logic                 clk,
  input logic                 reset,
  alu_mul_sequencer_if.slave  bus
);

  localparam logic [OPCODE_LENGTH-1:0] ALU_ADD = OPCODE_LENGTH'(4'b0010);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0] mplr_q, mplr_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  alu_req;
  logic                  step_ok;

  // The ALU is only needed when the current multiplier bit adds the multiplicand.
  assign alu_req = (state_q == RUN) && mplr_q[0];
  // A zero multiplier bit never needs the ALU, so only adding steps wait for a grant.
  assign step_ok = !mplr_q[0] || bus.alu_gnt;

  // Next-state and datapath: one multiplier bit retired per non-stalled RUN cycle.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplr_d   = mplr_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          acc_d   = '0;
          mcand_d = bus.op_a;
          mplr_d  = bus.op_b;
          if ((bus.op_a == '0) || (bus.op_b == '0)) begin
            state_d  = DONE;
            result_d = '0;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else if (step_ok) begin
          if (mplr_q[0]) begin
            acc_d = bus.alu_result;
          end
          mcand_d = mcand_q << 1;
          mplr_d  = mplr_q >> 1;
          // Post-shift multiplier is zero when only bit 0 remains: no step counter needed.
          if (mplr_q[DATA_WIDTH-1:1] == '0) begin
            state_d  = DONE;
            result_d = acc_d;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplr_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplr_q   <= mplr_d;
      result_q <= result_d;
    end
  end

  // Status and ALU operands are decoded straight from registered state, and the
  // operand bus is driven to zero whenever the ALU is not requested.
  always_comb begin
    bus.busy      = (state_q != IDLE);
    bus.done      = (state_q == DONE);
    bus.result    = result_q;
    bus.alu_req   = alu_req;
    bus.alu_src_a = alu_req ? acc_q   : '0;
    bus.alu_src_b = alu_req ? mcand_q : '0;
    bus.alu_op    = alu_req ? ALU_ADD : '0;
  end

endmodule
